led_frame_receiver: RTL and testbench

LED_FRAME_RECEIVER -- requirements
Module: led_frame_receiver

---
 rtl/led_frame_receiver_pkg.sv | 15 +
 rtl/spi_input_sync.sv | 42 ++++
 rtl/led_frame_receiver.sv | 149 ++++++++++++++
 tb/tb_led_frame_receiver.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/led_frame_receiver_pkg.sv
// Shared constants and receiver state encoding for the SPI LED frame receiver.
package led_frame_receiver_pkg;

  localparam logic [7:0] CMD_RESET_FRAME_INDEX = 8'h26;
  localparam int         PIXEL_COUNT           = 64;
  localparam logic [5:0] PIXEL_MAX             = 6'h3f;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    HOLD   = 2'd2,
    STREAM = 2'd3
  } rx_state_t;

endpackage

// File: rtl/spi_input_sync.sv
// Synchronises sclk/mosi/n_cs through identical flop chains and flags sclk/n_cs edges.
module spi_input_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset_async,
  input  logic sclk,
  input  logic mosi,
  input  logic n_cs,
  output logic mosi_sync,
  output logic cs_active,
  output logic sclk_rise,
  output logic cs_fall,
  output logic cs_rise
);

  logic [SYNC_STAGES-1:0] sclk_sr, mosi_sr, cs_sr;
  logic sclk_prev, cs_prev;

  always_ff @(posedge clock or posedge reset_async) begin
    if (reset_async) begin
      sclk_sr   <= '0;
      mosi_sr   <= '0;
      cs_sr     <= '1;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      sclk_sr   <= {sclk_sr[SYNC_STAGES-2:0], sclk};
      mosi_sr   <= {mosi_sr[SYNC_STAGES-2:0], mosi};
      cs_sr     <= {cs_sr[SYNC_STAGES-2:0], n_cs};
      sclk_prev <= sclk_sr[SYNC_STAGES-1];
      cs_prev   <= cs_sr[SYNC_STAGES-1];
    end
  end

  assign mosi_sync = mosi_sr[SYNC_STAGES-1];
  assign cs_active = ~cs_sr[SYNC_STAGES-1];
  assign sclk_rise = sclk_sr[SYNC_STAGES-1] & ~sclk_prev;
  assign cs_fall   = cs_prev & ~cs_sr[SYNC_STAGES-1];
  assign cs_rise   = ~cs_prev & cs_sr[SYNC_STAGES-1];

endmodule

// File: rtl/led_frame_receiver.sv
// SPI-fed 8x8 LED frame receiver: decodes chip-select windows into pixel writes or an index reset command.
module led_frame_receiver
  import led_frame_receiver_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset_async,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       n_cs,
  input  logic       err_clear,
  output logic       pix_valid,
  output logic [5:0] pix_addr,
  output logic [7:0] pix_data,
  output logic       frame_done,
  output logic       cmd_seen,
  output logic       overrun,
  output logic       byte_err
);

  localparam int IDX_W = $clog2(PIXEL_COUNT);

  logic mosi_sync, cs_active, sclk_rise, cs_fall, cs_rise;

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock       (clock),
    .reset_async (reset_async),
    .sclk        (sclk),
    .mosi        (mosi),
    .n_cs        (n_cs),
    .mosi_sync   (mosi_sync),
    .cs_active   (cs_active),
    .sclk_rise   (sclk_rise),
    .cs_fall     (cs_fall),
    .cs_rise     (cs_rise)
  );

  rx_state_t        state, state_next;
  logic [7:0]       shift, held;
  logic [2:0]       bit_cnt;
  logic             byte_done, pend, full;
  logic [IDX_W-1:0] idx;

  logic       wr_req, cmd, hold_load, pend_load;
  logic [7:0] wr_data;
  logic       do_wr, ov_set, be_set;
  logic [7:0] wdata;

  always_ff @(posedge clock or posedge reset_async) begin
    if (reset_async) state <= IDLE;
    else             state <= state_next;
  end

  always_comb begin
    state_next = state;
    wr_req     = 1'b0;
    wr_data    = shift;
    cmd        = 1'b0;
    hold_load  = 1'b0;
    pend_load  = 1'b0;
    unique case (state)
      IDLE:   if (cs_fall) state_next = FIRST;
      FIRST: begin
        if (byte_done) begin
          hold_load  = 1'b1;
          state_next = HOLD;
        end else if (cs_rise) begin
          state_next = IDLE;
        end
      end
      HOLD: begin
        // Second byte proves this is a pixel stream: flush the held byte now, the new one next cycle.
        if (byte_done) begin
          wr_req     = 1'b1;
          wr_data    = held;
          pend_load  = 1'b1;
          state_next = STREAM;
        end else if (cs_rise) begin
          if (held == CMD_RESET_FRAME_INDEX) cmd = 1'b1;
          else begin
            wr_req  = 1'b1;
            wr_data = held;
          end
          state_next = IDLE;
        end
      end
      STREAM: begin
        if (byte_done)    wr_req     = 1'b1;
        else if (cs_rise) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The pending byte stays in the shift register: the next sclk rise is several clocks away.
  assign do_wr  = wr_req | pend;
  assign wdata  = pend ? shift : wr_data;
  assign ov_set = do_wr & full & ~cmd;
  assign be_set = cs_rise & (bit_cnt != 3'd0);

  always_ff @(posedge clock or posedge reset_async) begin
    if (reset_async) begin
      shift      <= '0;
      bit_cnt    <= '0;
      byte_done  <= 1'b0;
      held       <= '0;
      pend       <= 1'b0;
      idx        <= '0;
      full       <= 1'b0;
      pix_valid  <= 1'b0;
      pix_addr   <= '0;
      pix_data   <= '0;
      frame_done <= 1'b0;
      cmd_seen   <= 1'b0;
      overrun    <= 1'b0;
      byte_err   <= 1'b0;
    end else begin
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
      cmd_seen   <= cmd;
      byte_done  <= sclk_rise & cs_active & ~cs_fall & (bit_cnt == 3'd7);
      pend       <= pend_load;
      if (cs_fall) begin
        bit_cnt <= '0;
      end else if (sclk_rise && cs_active) begin
        shift   <= {shift[6:0], mosi_sync};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (hold_load) held <= shift;
      if (cmd) begin
        idx  <= '0;
        full <= 1'b0;
      end else if (do_wr && !full) begin
        pix_valid <= 1'b1;
        pix_addr  <= idx;
        pix_data  <= wdata;
        idx       <= idx + 6'd1;
        if (idx == PIXEL_MAX) begin
          frame_done <= 1'b1;
          full       <= 1'b1;
        end
      end
      overrun  <= ov_set | (overrun & ~err_clear);
      byte_err <= be_set | (byte_err & ~err_clear);
    end
  end

endmodule

// File: tb/tb_led_frame_receiver.sv
// Directed and randomized SPI windows checked against a window-level model of the receiver.
module tb_led_frame_receiver;

  localparam int SS = 2;
  localparam logic [7:0] CMD = 8'h26;

  logic clock = 1'b0;
  logic reset_async = 1'b1;
  logic sclk = 1'b0, mosi = 1'b0, n_cs = 1'b1, err_clear = 1'b0;
  logic       pix_valid, frame_done, cmd_seen, overrun, byte_err;
  logic [5:0] pix_addr;
  logic [7:0] pix_data;

  led_frame_receiver #(.SYNC_STAGES(SS)) dut (
    .clock(clock), .reset_async(reset_async), .sclk(sclk), .mosi(mosi), .n_cs(n_cs),
    .err_clear(err_clear), .pix_valid(pix_valid), .pix_addr(pix_addr), .pix_data(pix_data),
    .frame_done(frame_done), .cmd_seen(cmd_seen), .overrun(overrun), .byte_err(byte_err)
  );

  always #5 clock = ~clock;

  int n_cmp = 0, n_err = 0;
  int cyc = 0, last_cap = 0;
  int obs_addr[$], obs_data[$], obs_fd[$], obs_cyc[$];
  int obs_cmd = 0, stray_fd = 0;
  int exp_addr[$], exp_data[$], exp_fd[$];
  int exp_cmd = 0;
  int m_idx = 0, m_full = 0, m_ovr = 0, m_berr = 0, m_last_addr = 0, m_last_data = 0;
  logic [7:0] win_q[$];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (pix_valid) begin
      obs_addr.push_back(int'(pix_addr));
      obs_data.push_back(int'(pix_data));
      obs_fd.push_back(int'(frame_done));
      obs_cyc.push_back(cyc);
    end
    if (cmd_seen) obs_cmd++;
    if (frame_done && !pix_valid) stray_fd++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_write(input logic [7:0] b);
    if (m_full != 0) m_ovr = 1;
    else begin
      exp_addr.push_back(m_idx);
      exp_data.push_back(int'(b));
      exp_fd.push_back(m_idx == 63 ? 1 : 0);
      m_last_addr = m_idx;
      m_last_data = int'(b);
      if (m_idx == 63) m_full = 1;
      m_idx = (m_idx + 1) % 64;
    end
  endtask

  task automatic model_window(input int partial);
    if (win_q.size() == 1 && win_q[0] == CMD) begin
      m_idx = 0; m_full = 0; exp_cmd++;
    end else begin
      foreach (win_q[i]) model_write(win_q[i]);
    end
    if (partial != 0) m_berr = 1;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      mosi = b[7-i];
      #40 sclk = 1'b1;
      if (i == 7) last_cap = cyc + 1;
      #40 sclk = 1'b0;
    end
  endtask

  task automatic run_window(input int partial);
    n_cs = 1'b0;
    #100;
    foreach (win_q[i]) send_bits(win_q[i], 8);
    if (partial != 0) send_bits(8'($urandom), partial);
    #60 n_cs = 1'b1;
    #300;
    model_window(partial);
  endtask

  task automatic cmd_window();
    win_q.delete();
    win_q.push_back(CMD);
    run_window(0);
  endtask

  task automatic pulse_err_clear();
    @(negedge clock) err_clear = 1'b1;
    @(negedge clock) err_clear = 1'b0;
    m_ovr = 0; m_berr = 0;
    #20;
  endtask

  task automatic check_all(input string tag);
    int n;
    chk({tag, ".nwr"}, obs_addr.size(), exp_addr.size());
    n = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, ".addr"}, obs_addr[i], exp_addr[i]);
      chk({tag, ".data"}, obs_data[i], exp_data[i]);
      chk({tag, ".fd"},   obs_fd[i],   exp_fd[i]);
    end
    chk({tag, ".cmd"}, obs_cmd, exp_cmd);
    chk({tag, ".ovr"}, overrun, m_ovr);
    chk({tag, ".berr"}, byte_err, m_berr);
    chk({tag, ".stray_fd"}, stray_fd, 0);
    chk({tag, ".hold_addr"}, pix_addr, m_last_addr);
    chk({tag, ".hold_data"}, pix_data, m_last_data);
    obs_addr.delete(); obs_data.delete(); obs_fd.delete(); obs_cyc.delete();
    exp_addr.delete(); exp_data.delete(); exp_fd.delete();
  endtask

  initial begin
    #30;
    chk("rst.pix_valid", pix_valid, 0);
    chk("rst.pix_addr", pix_addr, 0);
    chk("rst.pix_data", pix_data, 0);
    chk("rst.frame_done", frame_done, 0);
    chk("rst.cmd_seen", cmd_seen, 0);
    chk("rst.overrun", overrun, 0);
    chk("rst.byte_err", byte_err, 0);
    reset_async = 1'b0;
    #50;

    cmd_window();
    check_all("cmd_only");

    cmd_window();
    win_q.delete();
    for (int i = 0; i < 64; i++) win_q.push_back(8'(i));
    run_window(0);
    chk("latency", obs_cyc[obs_cyc.size()-1] - last_cap, SS + 1);
    check_all("frame64");

    cmd_window();
    win_q.delete();
    for (int i = 0; i < 65; i++) win_q.push_back(8'($urandom));
    run_window(0);
    check_all("frame65");
    pulse_err_clear();
    chk("ovr_cleared", overrun, 0);

    cmd_window();
    win_q.delete();
    win_q.push_back(CMD); win_q.push_back(CMD);
    run_window(0);
    chk("pair_consecutive", (obs_cyc.size() == 2) ? obs_cyc[1] - obs_cyc[0] : -1, 1);
    check_all("cmd_pair");

    cmd_window();
    win_q.delete();
    run_window(5);
    check_all("partial5");
    win_q.push_back(8'hA5);
    run_window(0);
    check_all("single_a5");
    pulse_err_clear();
    chk("berr_cleared", byte_err, 0);

    for (int w = 0; w < 8; w++) begin
      int len, part;
      len  = $urandom_range(0, 10);
      part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      win_q.delete();
      for (int i = 0; i < len; i++) win_q.push_back(8'($urandom));
      if (w == 3) begin win_q.delete(); win_q.push_back(CMD); end
      run_window(part);
      check_all("random");
      if (w == 5) pulse_err_clear();
    end

    cmd_window();
    check_all("pre_reset_cmd");
    win_q.delete();
    n_cs = 1'b0;
    #100;
    for (int i = 0; i < 3; i++) send_bits(8'($urandom), 8);
    send_bits(8'h5A, 4);
    reset_async = 1'b1;
    #1;
    chk("mid_rst.pix_valid", pix_valid, 0);
    chk("mid_rst.pix_addr", pix_addr, 0);
    chk("mid_rst.pix_data", pix_data, 0);
    chk("mid_rst.frame_done", frame_done, 0);
    chk("mid_rst.cmd_seen", cmd_seen, 0);
    chk("mid_rst.overrun", overrun, 0);
    chk("mid_rst.byte_err", byte_err, 0);
    #29 n_cs = 1'b1;
    #30 reset_async = 1'b0;
    #30;
    obs_addr.delete(); obs_data.delete(); obs_fd.delete(); obs_cyc.delete();
    m_idx = 0; m_full = 0; m_ovr = 0; m_berr = 0; m_last_addr = 0; m_last_data = 0;

    cmd_window();
    win_q.delete();
    for (int i = 0; i < 6; i++) win_q.push_back(8'($urandom));
    run_window(0);
    chk("post_rst.first_addr", (obs_addr.size() > 0) ? obs_addr[0] : -1, 0);
    check_all("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
